// File: rtl/riscv_pkg.sv
// Shared RISC-V opcode constants, controller state encoding and control-bundle type
// for the pipeline controller slice.
package riscv_pkg;

  localparam int unsigned OP_W    = 7;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned WAIT_W  = 8;
  localparam int unsigned STALL_W = 16;

  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OP_W-1:0] OP_S      = 7'b0100011;
  localparam logic [OP_W-1:0] OP_B      = 7'b1100011;
  localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_t;

  typedef struct packed {
    logic pc_we;
    logic pc_sel;
    logic ena_ifid;
    logic ena_idex;
    logic ena_exma;
    logic ena_mawb;
    logic hold_ifid;
    logic hold_all;
    logic halted;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN = '{
    pc_we:     1'b1,
    pc_sel:    1'b0,
    ena_ifid:  1'b1,
    ena_idex:  1'b1,
    ena_exma:  1'b1,
    ena_mawb:  1'b1,
    hold_ifid: 1'b0,
    hold_all:  1'b0,
    halted:    1'b0
  };

  function automatic logic is_mem_access(input logic [OP_W-1:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection: a LOAD in EX whose destination feeds a source
// register actually read by the instruction in ID.
module hazard_detect
  import riscv_pkg::*;
(
  input  logic [OP_W-1:0]  op_id,
  input  logic [REG_W-1:0] rs1_id,
  input  logic [REG_W-1:0] rs2_id,
  input  logic [OP_W-1:0]  op_ex,
  input  logic [REG_W-1:0] rd_ex,
  output logic             load_use_c
);

  logic reads_rs1;
  logic reads_rs2;

  // U-type and JAL carry no rs1; only R/S/B formats read rs2
  assign reads_rs1 = !(op_id inside {OP_LUI, OP_AUIPC, OP_JAL});
  assign reads_rs2 = op_id inside {OP_R, OP_S, OP_B};

  assign load_use_c = (op_ex == OP_LOAD) && (rd_ex != '0) &&
                      (((rd_ex == rs1_id) && reads_rs1) ||
                       ((rd_ex == rs2_id) && reads_rs2));

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline controller: stall/flush/hold generation, memory-wait
// tracking with timeout fault, halt handling and stall statistics.
module pipeline_ctrl
  import riscv_pkg::*;
#(
  parameter logic [WAIT_W-1:0] MEM_TIMEOUT = 8'd255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    op_id,
  input  logic [REG_W-1:0]   rs1_id,
  input  logic [REG_W-1:0]   rs2_id,
  input  logic [OP_W-1:0]    op_ex,
  input  logic [REG_W-1:0]   rd_ex,
  input  logic               branch_taken_ex,
  input  logic [OP_W-1:0]    op_ma,
  input  logic               mem_ready,
  output logic               pc_we,
  output logic               pc_sel,
  output logic               ena_ifid,
  output logic               ena_idex,
  output logic               ena_exma,
  output logic               ena_mawb,
  output logic               hold_ifid,
  output logic               hold_all,
  output logic               halted,
  output logic               mem_timeout,
  output logic [STALL_W-1:0] stall_cnt
);

  state_t              state;
  state_t              state_nxt;
  state_t              run_next;
  ctrl_t               ctrl;
  ctrl_t               run_ctrl;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [WAIT_W-1:0]   wait_nxt;
  logic                timeout_set;
  logic                load_use_c;
  logic                stall_cycle;

  hazard_detect u_hazard_detect (
    .op_id      (op_id),
    .rs1_id     (rs1_id),
    .rs2_id     (rs2_id),
    .op_ex      (op_ex),
    .rd_ex      (rd_ex),
    .load_use_c (load_use_c)
  );

  // Priority rules of the RUN state, reused by MEM_WAIT once memory is ready
  always_comb begin : run_rules
    run_ctrl = CTRL_RUN;
    run_next = ST_RUN;
    if (is_mem_access(op_ma) && !mem_ready) begin
      run_ctrl.hold_all = 1'b1;
      run_ctrl.pc_we    = 1'b0;
      run_next          = ST_MEM_WAIT;
    end else if (op_ma == OP_SYSTEM) begin
      run_ctrl.hold_all = 1'b1;
      run_ctrl.pc_we    = 1'b0;
      run_next          = ST_HALT;
    end else if (branch_taken_ex) begin
      run_ctrl.pc_sel   = 1'b1;
      run_ctrl.ena_ifid = 1'b0;
      run_ctrl.ena_idex = 1'b0;
    end else if (load_use_c) begin
      run_ctrl.pc_we     = 1'b0;
      run_ctrl.hold_ifid = 1'b1;
      run_ctrl.ena_idex  = 1'b0;
    end
  end

  always_comb begin : fsm_next
    ctrl        = CTRL_RUN;
    state_nxt   = state;
    wait_nxt    = '0;
    timeout_set = 1'b0;
    case (state)
      ST_RUN: begin
        ctrl      = run_ctrl;
        state_nxt = run_next;
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          ctrl      = run_ctrl;
          state_nxt = ST_RUN;
        end else begin
          ctrl.hold_all = 1'b1;
          ctrl.pc_we    = 1'b0;
          if (wait_cnt == MEM_TIMEOUT) begin
            timeout_set = 1'b1;
            state_nxt   = ST_HALT;
          end else begin
            wait_nxt = wait_cnt + WAIT_W'(1);
          end
        end
      end
      ST_HALT: begin
        ctrl.hold_all = 1'b1;
        ctrl.pc_we    = 1'b0;
        ctrl.halted   = 1'b1;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin : state_reg
    if (rst) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  assign stall_cycle = ctrl.hold_all || ctrl.hold_ifid;

  // Stall statistics saturate; the timeout fault is sticky until reset
  always_ff @(posedge clk or posedge rst) begin : stat_reg
    if (rst) begin
      stall_cnt   <= '0;
      mem_timeout <= 1'b0;
    end else begin
      if (stall_cycle && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + STALL_W'(1);
      end
      if (timeout_set) begin
        mem_timeout <= 1'b1;
      end
    end
  end

  assign pc_we     = ctrl.pc_we;
  assign pc_sel    = ctrl.pc_sel;
  assign ena_ifid  = ctrl.ena_ifid;
  assign ena_idex  = ctrl.ena_idex;
  assign ena_exma  = ctrl.ena_exma;
  assign ena_mawb  = ctrl.ena_mawb;
  assign hold_ifid = ctrl.hold_ifid;
  assign hold_all  = ctrl.hold_all;
  assign halted    = ctrl.halted;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed scenarios plus random traffic,
// expectations from a behavioural model, compared by an independent monitor.
module tb_pipeline_ctrl;

  localparam int unsigned TB_TIMEOUT = 4;

  localparam logic [6:0] C_LOAD   = 7'b0000011;
  localparam logic [6:0] C_STORE  = 7'b0100011;
  localparam logic [6:0] C_R      = 7'b0110011;
  localparam logic [6:0] C_B      = 7'b1100011;
  localparam logic [6:0] C_LUI    = 7'b0110111;
  localparam logic [6:0] C_AUIPC  = 7'b0010111;
  localparam logic [6:0] C_JAL    = 7'b1101111;
  localparam logic [6:0] C_ADDI   = 7'b0010011;
  localparam logic [6:0] C_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [6:0] op_id;
    logic [4:0] rs1_id;
    logic [4:0] rs2_id;
    logic [6:0] op_ex;
    logic [4:0] rd_ex;
    logic       br;
    logic [6:0] op_ma;
    logic       mem_ready;
  } stim_t;

  typedef struct packed {
    logic        pc_we;
    logic        pc_sel;
    logic        ena_ifid;
    logic        ena_idex;
    logic        ena_exma;
    logic        ena_mawb;
    logic        hold_ifid;
    logic        hold_all;
    logic        halted;
    logic        mem_timeout;
    logic [15:0] stall_cnt;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  op_id = '0, op_ex = '0, op_ma = '0;
  logic [4:0]  rs1_id = '0, rs2_id = '0, rd_ex = '0;
  logic        branch_taken_ex = 1'b0;
  logic        mem_ready = 1'b1;
  logic        pc_we, pc_sel, ena_ifid, ena_idex, ena_exma, ena_mawb;
  logic        hold_ifid, hold_all, halted, mem_timeout;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  obs_t  exp_q[$];
  string tag_q[$];

  // Model state: halted, waiting on memory, cycles waited, stalls, fault flag
  bit m_halt, m_wait, m_tmo;
  int m_wait_n, m_stalls;

  pipeline_ctrl #(.MEM_TIMEOUT(8'(TB_TIMEOUT))) dut (
    .clk             (clk),
    .rst             (rst),
    .op_id           (op_id),
    .rs1_id          (rs1_id),
    .rs2_id          (rs2_id),
    .op_ex           (op_ex),
    .rd_ex           (rd_ex),
    .branch_taken_ex (branch_taken_ex),
    .op_ma           (op_ma),
    .mem_ready       (mem_ready),
    .pc_we           (pc_we),
    .pc_sel          (pc_sel),
    .ena_ifid        (ena_ifid),
    .ena_idex        (ena_idex),
    .ena_exma        (ena_exma),
    .ena_mawb        (ena_mawb),
    .hold_ifid       (hold_ifid),
    .hold_all        (hold_all),
    .halted          (halted),
    .mem_timeout     (mem_timeout),
    .stall_cnt       (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit hazard(input stim_t s);
    bit r1, r2;
    r1 = !(s.op_id == C_LUI || s.op_id == C_AUIPC || s.op_id == C_JAL);
    r2 = (s.op_id == C_R || s.op_id == C_STORE || s.op_id == C_B);
    return (s.op_ex == C_LOAD) && (s.rd_ex != 0) &&
           ((s.rd_ex == s.rs1_id && r1) || (s.rd_ex == s.rs2_id && r2));
  endfunction

  task automatic model_reset();
    m_halt = 0; m_wait = 0; m_tmo = 0; m_wait_n = 0; m_stalls = 0;
  endtask

  // Expected outputs for this cycle, then advance the model across the edge
  task automatic model_eval(input stim_t s, output obs_t e);
    bit is_mem;
    bit leaving;
    e = '0;
    e.pc_we = 1; e.ena_ifid = 1; e.ena_idex = 1; e.ena_exma = 1; e.ena_mawb = 1;
    e.mem_timeout = m_tmo;
    e.stall_cnt = 16'(m_stalls);
    is_mem = (s.op_ma == C_LOAD) || (s.op_ma == C_STORE);
    if (m_halt) begin
      e.hold_all = 1; e.pc_we = 0; e.halted = 1;
    end else if (m_wait && !s.mem_ready) begin
      e.hold_all = 1; e.pc_we = 0;
      if (m_wait_n == TB_TIMEOUT) begin
        m_tmo = 1; m_halt = 1; m_wait = 0;
      end else begin
        m_wait_n++;
      end
    end else begin
      leaving = m_wait;
      m_wait = 0; m_wait_n = 0;
      if (is_mem && !s.mem_ready) begin
        e.hold_all = 1; e.pc_we = 0; m_wait = 1;
      end else if (s.op_ma == C_SYSTEM) begin
        e.hold_all = 1; e.pc_we = 0;
        if (!leaving) m_halt = 1;
      end else if (s.br) begin
        e.pc_sel = 1; e.ena_ifid = 0; e.ena_idex = 0;
      end else if (hazard(s)) begin
        e.pc_we = 0; e.hold_ifid = 1; e.ena_idex = 0;
      end
    end
    if ((e.hold_all || e.hold_ifid) && m_stalls < 65535) m_stalls++;
  endtask

  task automatic drive(input stim_t s, input bit pulse_rst, input string tag);
    obs_t e;
    @(posedge clk);
    #1;
    op_id = s.op_id; rs1_id = s.rs1_id; rs2_id = s.rs2_id;
    op_ex = s.op_ex; rd_ex = s.rd_ex; branch_taken_ex = s.br;
    op_ma = s.op_ma; mem_ready = s.mem_ready;
    if (pulse_rst) begin
      #1;
      rst = 1'b1;
      model_reset();
    end
    model_eval(s, e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    if (pulse_rst) begin
      @(negedge clk);
      #2;
      rst = 1'b0;
    end
  endtask

  function automatic logic [6:0] rand_op();
    case ($urandom_range(0, 9))
      0: return C_LOAD;
      1: return C_STORE;
      2: return C_R;
      3: return C_B;
      4: return C_LUI;
      5: return C_AUIPC;
      6: return C_JAL;
      7: return C_ADDI;
      8: return C_LOAD;
      default: return C_R;
    endcase
  endfunction

  // Monitor: one observation per cycle, away from the active edge
  initial begin : monitor
    obs_t  e;
    obs_t  got;
    string t;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        got = {pc_we, pc_sel, ena_ifid, ena_idex, ena_exma, ena_mawb,
               hold_ifid, hold_all, halted, mem_timeout, stall_cnt};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL %s @%0t: got %h (stall_cnt=%0d) exp %h (stall_cnt=%0d)",
                   t, $time, got, got.stall_cnt, e, e.stall_cnt);
        end
      end
    end
  end

  initial begin : stimulus
    stim_t idle;
    stim_t s;
    idle = '0;
    idle.op_id = C_ADDI; idle.op_ex = C_R; idle.op_ma = C_R; idle.mem_ready = 1'b1;
    model_reset();

    drive(idle, 1'b1, "reset");
    repeat (2) drive(idle, 1'b0, "idle");

    // single load-use bubble via rs2 of an R-type
    s = idle; s.op_ex = C_LOAD; s.rd_ex = 5'd5; s.op_id = C_R; s.rs1_id = 5'd1; s.rs2_id = 5'd5;
    drive(s, 1'b0, "load_use");
    drive(idle, 1'b0, "after_load_use");

    // destination x0 never stalls
    s = idle; s.op_ex = C_LOAD; s.rd_ex = 5'd0; s.op_id = C_R; s.rs1_id = 5'd0; s.rs2_id = 5'd0;
    drive(s, 1'b0, "rd_zero");

    // rs2 match ignored for an I-type; rs1 ignored for LUI
    s = idle; s.op_ex = C_LOAD; s.rd_ex = 5'd7; s.op_id = C_ADDI; s.rs1_id = 5'd2; s.rs2_id = 5'd7;
    drive(s, 1'b0, "itype_rs2");
    s.op_id = C_LUI; s.rs1_id = 5'd7;
    drive(s, 1'b0, "lui_rs1");

    // branch wins over load-use
    s = idle; s.op_ex = C_LOAD; s.rd_ex = 5'd3; s.op_id = C_B; s.rs1_id = 5'd3; s.br = 1'b1;
    drive(s, 1'b0, "branch_vs_lu");

    // three-cycle memory wait then ready
    drive(idle, 1'b1, "reset2");
    s = idle; s.op_ma = C_LOAD; s.mem_ready = 1'b0;
    repeat (3) drive(s, 1'b0, "mem_wait");
    s.mem_ready = 1'b1;
    drive(s, 1'b0, "mem_ready");
    drive(idle, 1'b0, "after_wait");

    // asynchronous reset mid-wait lands in RUN with cleared counters
    s = idle; s.op_ma = C_STORE; s.mem_ready = 1'b0;
    repeat (2) drive(s, 1'b0, "wait_pre_rst");
    s = idle; s.mem_ready = 1'b0;
    drive(s, 1'b1, "async_rst");
    drive(idle, 1'b0, "post_rst");

    // store never completes: timeout fault and halt persist until reset
    s = idle; s.op_ma = C_STORE; s.mem_ready = 1'b0;
    repeat (8) drive(s, 1'b0, "timeout");
    for (int i = 0; i < 4; i++) begin
      s = idle; s.op_ma = rand_op(); s.mem_ready = 1'($urandom_range(0, 1));
      s.br = 1'($urandom_range(0, 1));
      drive(s, 1'b0, "halt_sticky");
    end
    drive(idle, 1'b1, "reset_clears");
    drive(idle, 1'b0, "run_after_rst");

    // SYSTEM in MA halts
    s = idle; s.op_ma = C_SYSTEM;
    drive(s, 1'b0, "system");
    repeat (3) drive(idle, 1'b0, "halted");
    drive(idle, 1'b1, "reset3");

    // randomized traffic with small register range to provoke hazards
    for (int n = 0; n < 600; n++) begin
      s.op_id     = rand_op();
      s.rs1_id    = 5'($urandom_range(0, 3));
      s.rs2_id    = 5'($urandom_range(0, 3));
      s.op_ex     = rand_op();
      s.rd_ex     = 5'($urandom_range(0, 3));
      s.br        = ($urandom_range(0, 5) == 0);
      s.op_ma     = ($urandom_range(0, 49) == 0) ? C_SYSTEM : rand_op();
      s.mem_ready = ($urandom_range(0, 9) < 7);
      drive(s, ($urandom_range(0, 59) == 0), "random");
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
